// File: rtl/ble_telemetry_tx_if.sv
// Signal bundle between the telemetry frame source and the BLE UART transmitter.
interface ble_telemetry_tx_if #(
   parameter int NUM_BYTES = 10
);
   logic                   send_req;
   logic [NUM_BYTES*8-1:0] payload;
   logic                   txd;
   logic                   busy;
   logic                   done;
   logic [7:0]             dropped_cnt;

   modport master (
      output send_req, payload,
      input  txd, busy, done, dropped_cnt
   );

   modport slave (
      input  send_req, payload,
      output txd, busy, done, dropped_cnt
   );
endinterface

// File: rtl/ble_telemetry_tx.sv
// Sends one framed telemetry packet (sync, payload, XOR checksum, newline) as 8N1 UART
// on request, snapshotting the payload at accept time.
module ble_telemetry_tx #(
   parameter int         CLK_FREQ  = 100_000_000,
   parameter int         BAUD      = 115200,
   parameter int         NUM_BYTES = 10,
   parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
   input logic               clk,
   input logic               rst,
   ble_telemetry_tx_if.slave bus
);
   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int FRAME_LEN    = NUM_BYTES + 3;
   localparam int BIDX_W       = $clog2(FRAME_LEN);
   localparam int FRAME_SLOTS  = 1 << BIDX_W;

   typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

   function automatic logic [7:0] xor_bytes(input logic [NUM_BYTES*8-1:0] v);
      logic [7:0] x;
      x = 8'h00;
      for (int k = 0; k < NUM_BYTES; k++) begin
         x = x ^ v[8*k +: 8];
      end
      return x;
   endfunction

   state_t                 state_r, state_nxt_s;
   logic [CNT_W-1:0]       clk_cnt_r, clk_cnt_nxt_s;
   logic [2:0]             bit_idx_r, bit_idx_nxt_s;
   logic [BIDX_W-1:0]      byte_idx_r, byte_idx_nxt_s;
   logic [NUM_BYTES*8-1:0] payload_r;
   logic [7:0]             csum_s;
   logic [7:0]             frame_s [FRAME_SLOTS];
   logic                   bit_end_s, last_byte_s, accept_s;
   logic                   txd_nxt_s, busy_nxt_s, done_nxt_s;
   logic                   txd_r, busy_r, done_r;
   logic [7:0]             dropped_r;

   assign bit_end_s   = (clk_cnt_r == CNT_W'(CLKS_PER_BIT - 1));
   assign last_byte_s = (byte_idx_r == BIDX_W'(FRAME_LEN - 1));
   assign accept_s    = (state_r == ST_IDLE) && bus.send_req;
   assign csum_s      = xor_bytes(payload_r);

   // Byte-select table indexed by byte position; unused slots pad the index range.
   always_comb begin
      for (int k = 0; k < FRAME_SLOTS; k++) begin
         frame_s[k] = 8'hFF;
      end
      frame_s[0] = SYNC_BYTE;
      for (int k = 0; k < NUM_BYTES; k++) begin
         frame_s[k+1] = payload_r[8*k +: 8];
      end
      frame_s[NUM_BYTES+1] = csum_s;
      frame_s[NUM_BYTES+2] = 8'h0A;
   end

   // State, bit/byte counters and payload snapshot.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         clk_cnt_r  <= '0;
         bit_idx_r  <= 3'd0;
         byte_idx_r <= '0;
         payload_r  <= '0;
      end else begin
         state_r    <= state_nxt_s;
         clk_cnt_r  <= clk_cnt_nxt_s;
         bit_idx_r  <= bit_idx_nxt_s;
         byte_idx_r <= byte_idx_nxt_s;
         if (accept_s) begin
            payload_r <= bus.payload;
         end
      end
   end

   // Next-state and counter sequencing through start, data and stop bits of each byte.
   always_comb begin
      state_nxt_s    = state_r;
      clk_cnt_nxt_s  = clk_cnt_r + CNT_W'(1);
      bit_idx_nxt_s  = bit_idx_r;
      byte_idx_nxt_s = byte_idx_r;
      case (state_r)
         ST_IDLE: begin
            clk_cnt_nxt_s = '0;
            if (accept_s) begin
               state_nxt_s    = ST_START;
               bit_idx_nxt_s  = 3'd0;
               byte_idx_nxt_s = '0;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_START: begin
            if (bit_end_s) begin
               state_nxt_s   = ST_DATA;
               clk_cnt_nxt_s = '0;
               bit_idx_nxt_s = 3'd0;
            end else begin
               state_nxt_s = ST_START;
            end
         end
         ST_DATA: begin
            if (bit_end_s) begin
               clk_cnt_nxt_s = '0;
               if (bit_idx_r == 3'd7) begin
                  state_nxt_s = ST_STOP;
               end else begin
                  bit_idx_nxt_s = bit_idx_r + 3'd1;
               end
            end else begin
               state_nxt_s = ST_DATA;
            end
         end
         ST_STOP: begin
            if (bit_end_s) begin
               clk_cnt_nxt_s = '0;
               if (last_byte_s) begin
                  state_nxt_s    = ST_IDLE;
                  byte_idx_nxt_s = '0;
               end else begin
                  state_nxt_s    = ST_START;
                  byte_idx_nxt_s = byte_idx_r + BIDX_W'(1);
               end
            end else begin
               state_nxt_s = ST_STOP;
            end
         end
         default: begin
            state_nxt_s    = ST_IDLE;
            clk_cnt_nxt_s  = '0;
            bit_idx_nxt_s  = 3'd0;
            byte_idx_nxt_s = '0;
         end
      endcase
   end

   // Outputs derived from the upcoming state so the registered line changes on the bit boundary.
   always_comb begin
      txd_nxt_s  = 1'b1;
      busy_nxt_s = (state_nxt_s != ST_IDLE);
      done_nxt_s = (state_r == ST_STOP) && bit_end_s && last_byte_s;
      case (state_nxt_s)
         ST_IDLE:  txd_nxt_s = 1'b1;
         ST_START: txd_nxt_s = 1'b0;
         ST_DATA:  txd_nxt_s = frame_s[byte_idx_nxt_s][bit_idx_nxt_s];
         ST_STOP:  txd_nxt_s = 1'b1;
         default:  txd_nxt_s = 1'b1;
      endcase
   end

   // Glitch-free registered outputs and saturating dropped-request counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         txd_r     <= 1'b1;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         dropped_r <= 8'd0;
      end else begin
         txd_r  <= txd_nxt_s;
         busy_r <= busy_nxt_s;
         done_r <= done_nxt_s;
         if (bus.send_req && busy_r && (dropped_r != 8'hFF)) begin
            dropped_r <= dropped_r + 8'd1;
         end
      end
   end

   assign bus.txd         = txd_r;
   assign bus.busy        = busy_r;
   assign bus.done        = done_r;
   assign bus.dropped_cnt = dropped_r;
endmodule
